// File: rtl/recip_scale_pkg.sv
// recip_scale_pkg: shared constants and types for the gain-scaling stage.
//   FRAC_W_DEF  default number of fractional gain bits
//   GAIN_ONE    unity gain (1.0) at the default FRAC_W
//   SAT_MAX/MIN signed 16-bit output clip limits
//   state_e     burst FSM states
package recip_scale_pkg;
   localparam int FRAC_W_DEF = 10;
   localparam logic [15:0] GAIN_ONE = 16'(1 << FRAC_W_DEF);
   localparam logic signed [15:0] SAT_MAX = 16'sh7fff;
   localparam logic signed [15:0] SAT_MIN = 16'sh8000;

   typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/recip_scale_if.sv
// recip_scale_if: the three req/ack streams of the scaler.
//   t_0_*  gain token in (unsigned)
//   t_1_*  sample in (signed)
//   i_2_*  scaled sample out (signed)
// master = producer of the inputs / consumer of the output; slave = the scaler.
interface recip_scale_if;
   logic [15:0] t_0_dat;
   logic        t_0_req;
   logic        t_0_ack;
   logic [15:0] t_1_dat;
   logic        t_1_req;
   logic        t_1_ack;
   logic [15:0] i_2_dat;
   logic        i_2_req;
   logic        i_2_ack;

   modport master (output t_0_dat, t_0_req, input t_0_ack,
                   output t_1_dat, t_1_req, input t_1_ack,
                   input i_2_dat, i_2_req, output i_2_ack);
   modport slave  (input t_0_dat, t_0_req, output t_0_ack,
                   input t_1_dat, t_1_req, output t_1_ack,
                   output i_2_dat, i_2_req, input i_2_ack);
endinterface

// File: rtl/recip_scale_mul_sat.sv
// recip_scale_mul_sat: combinational arithmetic for both pipeline stages.
//   sample, gain -> prod     signed 16 x unsigned 16 product, 33 bits (feeds stage 1)
//   prod_in      -> res, sat round half toward +inf, shift by FRAC_W, clip to
//                            16-bit signed; sat flags a clipped result (feeds stage 2)
module recip_scale_mul_sat
   import recip_scale_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic signed [15:0] sample,
   input  logic        [15:0] gain,
   output logic signed [32:0] prod,
   input  logic signed [32:0] prod_in,
   output logic signed [15:0] res,
   output logic               sat
);
   localparam logic signed [33:0] HALF = 34'sd1 <<< (FRAC_W - 1);

   logic signed [32:0] s_ext;
   logic signed [32:0] g_ext;
   logic signed [33:0] sum;
   logic signed [33:0] rnd;

   // Gain is zero-extended so it is treated as positive in the signed multiply.
   assign s_ext = 33'(sample);
   assign g_ext = 33'($signed({1'b0, gain}));
   assign prod  = s_ext * g_ext;

   // One extra bit keeps the rounding add from overflowing at the extremes.
   assign sum = 34'(prod_in) + HALF;
   assign rnd = sum >>> FRAC_W;

   always_comb begin
      res = rnd[15:0];
      sat = 1'b0;
      if (rnd > 34'(SAT_MAX)) begin
         res = SAT_MAX;
         sat = 1'b1;
      end else if (rnd < 34'(SAT_MIN)) begin
         res = SAT_MIN;
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/recip_scale.sv
// recip_scale: accepts one gain token, then scales the next BURST_LEN signed
// samples by it (multiply, round, saturate) through a 2-stage req/ack pipeline.
//   clk, reset_n  clock, async active-low reset
//   bus           recip_scale_if.slave: gain in, sample in, scaled out
//   busy          burst active or pipeline holds data
//   sat_cnt       clipped-output count, only when RECIP_SCALE_SAT_CNT_EN is defined
module recip_scale
   import recip_scale_pkg::*;
#(
   parameter int FRAC_W    = FRAC_W_DEF,
   parameter int BURST_LEN = 64
) (
   input  logic          clk,
   input  logic          reset_n,
   recip_scale_if.slave  bus,
   output logic          busy
`ifdef RECIP_SCALE_SAT_CNT_EN
   ,
   output logic [15:0]   sat_cnt
`endif
);
   localparam logic [15:0] LAST = 16'(BURST_LEN - 1);

   state_e             state_q, state_d;
   logic        [15:0] cnt_q, cnt_d;
   logic        [15:0] gain_q, gain_d;
   logic               v1_q, v1_d;
   logic               v2_q, v2_d;
   logic signed [32:0] prod_q, prod_d;
   logic signed [15:0] out_q, out_d;

   logic               adv2, g_xfer, s_xfer, s2_load;
   logic signed [32:0] prod_mul;
   logic signed [15:0] res_mul;
   logic               sat_mul;

   recip_scale_mul_sat #(.FRAC_W(FRAC_W)) u_mul_sat (
      .sample  (bus.t_1_dat),
      .gain    (gain_q),
      .prod    (prod_mul),
      .prod_in (prod_q),
      .res     (res_mul),
      .sat     (sat_mul)
   );

   // Stage 2 can take new data when empty or when its output is leaving.
   assign adv2    = ~v2_q | bus.i_2_ack;
   assign s2_load = adv2 & v1_q;
   assign g_xfer  = bus.t_0_req & bus.t_0_ack;
   assign s_xfer  = bus.t_1_req & bus.t_1_ack;

   assign bus.t_0_ack = (state_q == IDLE);
   assign bus.t_1_ack = (state_q == ACTIVE) & (~v1_q | adv2);
   assign bus.i_2_req = v2_q;
   assign bus.i_2_dat = out_q;
   assign busy        = (state_q == ACTIVE) | v1_q | v2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gain_d  = gain_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      prod_d  = prod_q;
      out_d   = out_q;
      case (state_q)
         IDLE: if (g_xfer) begin
            gain_d  = bus.t_0_dat;
            cnt_d   = '0;
            state_d = ACTIVE;
         end
         ACTIVE: if (s_xfer) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Stage 1 refills on a transfer, otherwise empties when stage 2 takes it.
      if (s_xfer) begin
         v1_d   = 1'b1;
         prod_d = prod_mul;
      end else if (adv2) begin
         v1_d = 1'b0;
      end
      if (adv2)    v2_d  = v1_q;
      if (s2_load) out_d = res_mul;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gain_q  <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         prod_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gain_q  <= gain_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         prod_q  <= prod_d;
         out_q   <= out_d;
      end
   end

`ifdef RECIP_SCALE_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Clear wins over a same-cycle clip from the previous burst's tail.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (g_xfer)
         sat_cnt_d = '0;
      else if (s2_load && sat_mul && sat_cnt_q != 16'hffff)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sat_cnt_q <= '0;
      else          sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif
endmodule

// File: tb/tb_recip_scale.sv
// tb_recip_scale: directed tests for recip_scale at FRAC_W=10.
// DUT a: BURST_LEN=4; DUT b: BURST_LEN=8 (backpressure burst). sel picks
// which DUT the shared stimulus drives and which outputs are observed.
// Define RECIP_SCALE_SAT_CNT_EN to also cover the saturation counter.
module tb_recip_scale;
   import recip_scale_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic [15:0] g_dat = '0, s_dat = '0;
   logic        g_req = 1'b0, s_req = 1'b0, o_ack = 1'b1;
   logic        bp_mon = 1'b0;
   logic        busy_a, busy_b;

   recip_scale_if bus_a ();
   recip_scale_if bus_b ();

   assign bus_a.t_0_dat = g_dat;
   assign bus_a.t_0_req = g_req & ~sel;
   assign bus_a.t_1_dat = s_dat;
   assign bus_a.t_1_req = s_req & ~sel;
   assign bus_a.i_2_ack = o_ack;
   assign bus_b.t_0_dat = g_dat;
   assign bus_b.t_0_req = g_req & sel;
   assign bus_b.t_1_dat = s_dat;
   assign bus_b.t_1_req = s_req & sel;
   assign bus_b.i_2_ack = o_ack;

`ifdef RECIP_SCALE_SAT_CNT_EN
   logic [15:0] sat_a, sat_b, sat_o;
   assign sat_o = sel ? sat_b : sat_a;
`endif

   recip_scale #(.FRAC_W(10), .BURST_LEN(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .busy(busy_a)
`ifdef RECIP_SCALE_SAT_CNT_EN
      , .sat_cnt(sat_a)
`endif
   );

   recip_scale #(.FRAC_W(10), .BURST_LEN(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .busy(busy_b)
`ifdef RECIP_SCALE_SAT_CNT_EN
      , .sat_cnt(sat_b)
`endif
   );

   logic        t0a, t1a, i2r, busy_o;
   logic [15:0] i2d;
   assign t0a    = sel ? bus_b.t_0_ack : bus_a.t_0_ack;
   assign t1a    = sel ? bus_b.t_1_ack : bus_a.t_1_ack;
   assign i2r    = sel ? bus_b.i_2_req : bus_a.i_2_req;
   assign i2d    = sel ? bus_b.i_2_dat : bus_a.i_2_dat;
   assign busy_o = sel ? busy_b : busy_a;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   logic [15:0] outq[$], expq[$], stim[$];
   int out_e[$], in_e[$], g_e[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (reset_n) begin
         if (i2r && o_ack) begin
            outq.push_back(i2d);
            out_e.push_back(cyc);
         end
         if (s_req && t1a) in_e.push_back(cyc);
         if (g_req && t0a) g_e.push_back(cyc);
         if (bp_mon && in_e.size() < 8 && !t1a)
            chk("bp_ack_drop", {30'b0, i2r, o_ack}, 32'h2);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      outq.delete(); out_e.delete(); in_e.delete(); g_e.delete(); expq.delete(); stim.delete();
   endtask

   task automatic send_gain(input logic [15:0] g);
      bit ok;
      ok = 0;
      g_dat = g;
      g_req = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (t0a) begin ok = 1; break; end
      end
      if (!ok) chk("gain_timeout", 0, 1);
      tick();
      g_req = 1'b0;
   endtask

   task automatic send_stim();
      bit ok;
      for (int i = 0; i < stim.size(); i++) begin
         ok = 0;
         s_dat = stim[i];
         s_req = 1'b1;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (t1a) begin ok = 1; break; end
         end
         if (!ok) chk("sample_timeout", 0, 1);
         tick();
         s_req = 1'b0;
      end
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < 300; k++) begin
         if (outq.size() >= n) break;
         tick();
      end
      if (outq.size() < n) chk("drain_timeout", outq.size(), n);
   endtask

   task automatic cmp_out(input string tag);
      chk({tag, "_count"}, outq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < outq.size(); i++)
         chk(tag, {16'h0, outq[i]}, {16'h0, expq[i]});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      // reset state
      chk("rst_t0_ack", t0a, 1);
      chk("rst_t1_ack", t1a, 0);
      chk("rst_i2_req", i2r, 0);
      chk("rst_i2_dat", i2d, 0);
      chk("rst_busy", busy_o, 0);
`ifdef RECIP_SCALE_SAT_CNT_EN
      chk("rst_sat_cnt", sat_o, 0);
`endif
      reset_n = 1'b1;
      tick();

      // 1. unity gain, latency, return to IDLE
      clr();
      send_gain(GAIN_ONE);
      chk("t1_busy", busy_o, 1);
      chk("t1_t0_ack_active", t0a, 0);
      stim = '{16'h1234, 16'hfedc, 16'h0000, 16'h7fff};
      send_stim();
      chk("t1_idle_after_last", t0a, 1);
      expq = '{16'h1234, 16'hfedc, 16'h0000, 16'h7fff};
      drain(4);
      cmp_out("t1_unity");
      for (int i = 0; i < 4 && i < out_e.size() && i < in_e.size(); i++)
         chk("t1_latency", out_e[i] - in_e[i], 2);
      tick(); tick();
      chk("t1_busy_done", busy_o, 0);

      // 2. saturation, gain 2.0
      clr();
      send_gain(16'h0800);
      stim = '{16'h5000, 16'h8000, 16'h0100, 16'hff00};
      send_stim();
      expq = '{16'h7fff, 16'h8000, 16'h0200, 16'hfe00};
      drain(4);
      cmp_out("t2_sat");
      tick();
`ifdef RECIP_SCALE_SAT_CNT_EN
      chk("t2_sat_cnt", sat_o, 2);
`endif

      // 3. rounding, gain 0.5, half toward +inf
      clr();
      send_gain(16'h0200);
      stim = '{16'h0003, 16'hfffd, 16'h0001, 16'hffff};
      send_stim();
      expq = '{16'h0002, 16'hffff, 16'h0001, 16'h0000};
      drain(4);
      cmp_out("t3_round");
`ifdef RECIP_SCALE_SAT_CNT_EN
      chk("t3_sat_cnt_cleared", sat_o, 0);
`endif

      // 5. gain gating, mid-burst gain change
      clr();
      s_dat = 16'h0005;
      s_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_idle_no_sample_ack", t1a, 0);
      end
      s_req = 1'b0;
      clr();
      send_gain(GAIN_ONE);
      g_e.delete();
      stim = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10, 16'd20, 16'd30, 16'd40};
      fork
         send_stim();
         begin
            for (int k = 0; k < 200 && in_e.size() < 2; k++) @(negedge clk);
            tick();
            g_dat = 16'h0800;
            g_req = 1'b1;
            chk("t5_gain_blocked", t0a, 0);
            for (int k = 0; k < 200 && g_e.size() < 1; k++) @(negedge clk);
            tick();
            g_req = 1'b0;
         end
      join
      chk("t5_gain_once", g_e.size(), 1);
      if (g_e.size() > 0 && in_e.size() > 3)
         chk("t5_gain_accept_cycle", g_e[0], in_e[3] + 1);
      expq = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd20, 16'd40, 16'd60, 16'd80};
      drain(8);
      cmp_out("t5_regain");

      // 4. backpressure, 8-sample burst on DUT b, gain 0.75
      sel = 1'b1;
      clr();
      send_gain(16'h0300);
      bp_mon = 1'b1;
      stim = '{16'd4, 16'd100, 16'hff9c, 16'd7, 16'hfff9, 16'd1000, 16'hffff, 16'h7fff};
      fork
         send_stim();
         begin
            for (int k = 0; k < 300 && outq.size() < 8; k++) begin
               tick();
               if (k >= 4 && k < 9) o_ack = 1'b0;
               else o_ack = 1'($urandom_range(0, 1));
            end
            o_ack = 1'b1;
         end
      join
      drain(8);
      bp_mon = 1'b0;
      expq = '{16'd3, 16'd75, 16'hffb5, 16'd5, 16'hfffb, 16'd750, 16'hffff, 16'd24575};
      cmp_out("t4_bp");
      tick(); tick();
      chk("t4_busy_done", busy_o, 0);
      sel = 1'b0;
      tick();

      // 6. reset mid-burst
      clr();
      send_gain(GAIN_ONE);
      stim = '{16'h0abc, 16'h0def};
      send_stim();
      reset_n = 1'b0;
      #1;
      chk("t6_rst_i2_req", i2r, 0);
      chk("t6_rst_i2_dat", i2d, 0);
      chk("t6_rst_t0_ack", t0a, 1);
      chk("t6_rst_t1_ack", t1a, 0);
      chk("t6_rst_busy", busy_o, 0);
      tick(); tick();
      clr();
      reset_n = 1'b1;
      repeat (5) tick();
      chk("t6_no_output_after_rst", outq.size(), 0);
      send_gain(GAIN_ONE);
      stim = '{16'h0111, 16'h0222, 16'h8000, 16'h7fff};
      send_stim();
      expq = '{16'h0111, 16'h0222, 16'h8000, 16'h7fff};
      drain(4);
      cmp_out("t6_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
